// File: rtl/tdc_therm_decoder_if.sv
// Handshake bundle for the thermometer decoder: encoded words in, thermometer words out.
// A word moves on a rising edge where valid and ready are both 1; a valid word and its
// payload stay unchanged until it moves, and ready may depend combinationally on valid.
interface tdc_therm_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_code;
  logic [9:0]  in_offset;
  logic        in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_therm;
  logic        out_err;

  modport master (
    output in_valid, in_code, in_offset, in_empty, out_ready,
    input  in_ready, out_valid, out_therm, out_err
  );

  modport slave (
    input  in_valid, in_code, in_offset, in_empty, out_ready,
    output in_ready, out_valid, out_therm, out_err
  );
endinterface

// File: rtl/tdc_therm_decoder.sv
// TDC segment decoder: rebuilds a 48-bit thermometer word from a fine code and checks
// the coarse offset; a sweep FSM can replay every legal word as a self-test.
module tdc_therm_decoder #(
  parameter int INDEX = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdc_therm_decoder_if.slave   bus,
  input  logic                 sweep_start,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic [7:0]           err_cnt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [9:0] EXP_OFF = 10'(INDEX * 48);
  localparam logic [5:0] LAST_K  = 6'd48;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        out_valid_q;
  logic [47:0] out_therm_q;
  logic        out_err_q;
  logic [7:0]  err_cnt_q;

  logic        can_load;
  logic        in_ready_c;
  logic        accept;
  logic        gen_load;
  logic [47:0] dec_therm;
  logic        dec_err;
  logic [47:0] gen_therm;

  // Word with the n lowest bits set; n may reach 48 (all ones).
  function automatic logic [47:0] low_ones(input logic [6:0] n);
    low_ones = ~({48{1'b1}} << n);
  endfunction

  assign can_load = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready_c;

  always_comb begin
    dec_therm = '0;
    dec_err   = 1'b0;
    if (!bus.in_empty) begin
      if (bus.in_code > 6'd47) begin
        dec_err = 1'b1;
      end else begin
        dec_therm = low_ones(7'(bus.in_code) + 7'd1);
        dec_err   = (bus.in_offset != EXP_OFF);
      end
    end
  end

  // Sweep word k has k ones: k=0 is the empty word, k>=1 is code k-1.
  assign gen_therm = low_ones({1'b0, cnt_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    gen_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A sweep request takes priority over a word offered in the same cycle.
        if (sweep_start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end else begin
          in_ready_c = can_load;
        end
      end
      S_SWEEP: begin
        if (can_load) begin
          gen_load = 1'b1;
          if (cnt_q == LAST_K) state_d = S_DONE;
          else                 cnt_d   = cnt_q + 6'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_therm_q <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_therm_q <= dec_therm;
      out_err_q   <= dec_err;
      if (dec_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end else if (gen_load) begin
      out_valid_q <= 1'b1;
      out_therm_q <= gen_therm;
      out_err_q   <= 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_therm = out_therm_q;
  assign bus.out_err   = out_err_q;
  assign err_cnt       = err_cnt_q;
  assign sweep_busy    = (state_q != S_IDLE);
  assign sweep_done    = (state_q == S_DONE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Bench for tdc_therm_decoder (INDEX=2, expected offset 96): directed words, stalls,
// sweeps, error-counter saturation and reset in the middle of a sweep.
module tb_tdc_therm_decoder;
  localparam int INDEX = 2;
  localparam int W     = 49;
  localparam logic [9:0] OFF = 10'd96;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sweep_start;
  logic       sweep_busy;
  logic       sweep_done;
  logic [7:0] err_cnt;
  logic [1:0] dbg_state;

  tdc_therm_decoder_if bus ();

  tdc_therm_decoder #(.INDEX(INDEX)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a word presented with out_ready=1 leaves at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {15'd0, bus.out_err, bus.out_therm}, 64'h0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("out_therm", 64'(bus.out_therm), 64'(e[47:0]));
        check("out_err", 64'(bus.out_err), 64'(e[48]));
        pop_cnt++;
      end
    end
    if (rst_n && sweep_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [5:0] code, input logic [9:0] off, input logic emp,
                           input logic [47:0] exp_therm, input logic exp_err, output int waits);
    logic ok;
    ok = 1'b0;
    waits = 0;
    bus.in_valid  = 1'b1;
    bus.in_code   = code;
    bus.in_offset = off;
    bus.in_empty  = emp;
    while (!ok && waits < 100) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back({exp_err, exp_therm});
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'h1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'h0);
  endtask

  // Sweep reference built bit by bit: word k has bits [k-1:0] set.
  task automatic push_sweep();
    logic [47:0] t;
    for (int k = 0; k <= 48; k++) begin
      t = '0;
      for (int i = 0; i < k; i++) t[i] = 1'b1;
      exp_q.push_back({1'b0, t});
    end
  endtask

  task automatic pulse_sweep();
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int w, wb, wsum, d0, base, n;
  logic seen;

  initial begin
    bus.in_valid = 1'b0; bus.in_code = '0; bus.in_offset = '0; bus.in_empty = 1'b0;
    bus.out_ready = 1'b1;
    sweep_start = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_therm", 64'(bus.out_therm), 64'h0);
    check("rst_err_cnt", 64'(err_cnt), 64'h0);
    check("rst_sweep_busy", 64'(sweep_busy), 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed words, back to back
    send_word(6'd5,  OFF, 1'b0, 48'h0000_0000_003F, 1'b0, w);
    check("first_accept_wait", 64'(w), 64'h0);
    wsum = 0;
    send_word(6'd47, OFF,    1'b0, 48'hFFFF_FFFF_FFFF, 1'b0, w); wsum += w;
    send_word(6'd47, 10'd48, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1, w); wsum += w;
    send_word(6'd50, OFF,    1'b0, 48'h0,              1'b1, w); wsum += w;
    send_word(6'd50, OFF,    1'b1, 48'h0,              1'b0, w); wsum += w;
    send_word(6'd0,  OFF,    1'b0, 48'h0000_0000_0001, 1'b0, w); wsum += w;
    send_word(6'd63, OFF,    1'b0, 48'h0,              1'b1, w); wsum += w;
    send_word(6'd23, OFF,    1'b0, 48'h0000_00FF_FFFF, 1'b0, w); wsum += w;
    send_word(6'd24, 10'd97, 1'b0, 48'h0000_01FF_FFFF, 1'b1, w); wsum += w;
    send_word(6'd9,  10'd0,  1'b1, 48'h0,              1'b0, w); wsum += w;
    check("throughput_waits", 64'(wsum), 64'h0);
    wait_drain();
    check("err_cnt_directed", 64'(err_cnt), 64'd4);
    check("idle_out_valid", 64'(bus.out_valid), 64'h0);

    // Downstream stall: second word waits three cycles, both delivered in order
    bus.out_ready = 1'b0;
    send_word(6'd10, OFF, 1'b0, 48'h0000_0000_07FF, 1'b0, w);
    fork
      send_word(6'd11, OFF, 1'b0, 48'h0000_0000_0FFF, 1'b0, wb);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(bus.in_ready), 64'h0);
          check("stall_out_valid", 64'(bus.out_valid), 64'h1);
          check("stall_out_therm", 64'(bus.out_therm), 64'h7FF);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    check("stall_waits", 64'(wb), 64'd3);
    wait_drain();

    // Sweep: start collides with an offered word, which must not be taken
    d0 = done_cnt;
    push_sweep();
    bus.in_valid = 1'b1; bus.in_code = 6'd5; bus.in_offset = OFF; bus.in_empty = 1'b0;
    sweep_start = 1'b1;
    @(negedge clk);
    check("sweep_wins_in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk); #1;
    sweep_start = 1'b0; bus.in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("sweep_busy", 64'(sweep_busy), 64'h1);
    pulse_sweep();
    seen = 1'b0; n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (sweep_done) seen = 1'b1;
      n++;
    end
    check("sweep_done_seen", 64'(seen), 64'h1);
    @(negedge clk);
    check("sweep_done_pulse", 64'(sweep_done), 64'h0);
    check("sweep_busy_after", 64'(sweep_busy), 64'h0);
    @(posedge clk); #1;
    wait_drain();
    check("sweep_done_count", 64'(done_cnt - d0), 64'h1);
    check("err_cnt_after_sweep", 64'(err_cnt), 64'd4);

    // Sweep with random downstream stalls
    d0 = done_cnt;
    push_sweep();
    pulse_sweep();
    seen = 1'b0; n = 0;
    while (!seen && n < 1000) begin
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (sweep_done) seen = 1'b1;
      n++;
    end
    check("stall_sweep_done", 64'(seen), 64'h1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain();
    check("stall_sweep_done_count", 64'(done_cnt - d0), 64'h1);

    // Error counter saturates at 255
    wsum = 0;
    for (int i = 0; i < 260; i++) begin
      send_word(6'd63, OFF, 1'b0, 48'h0, 1'b1, w);
      wsum += w;
    end
    wait_drain();
    check("sat_waits", 64'(wsum), 64'h0);
    check("err_cnt_saturated", 64'(err_cnt), 64'd255);

    // Reset in the middle of a sweep
    d0 = done_cnt;
    base = pop_cnt;
    push_sweep();
    pulse_sweep();
    n = 0;
    while (pop_cnt < base + 20 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("mid_sweep_reached", 64'(pop_cnt - base >= 20), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("mid_rst_out_therm", 64'(bus.out_therm), 64'h0);
    check("mid_rst_out_err", 64'(bus.out_err), 64'h0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'h0);
    check("mid_rst_busy", 64'(sweep_busy), 64'h0);
    check("mid_rst_done", 64'(sweep_done), 64'h0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'h1);
    check("post_rst_state", 64'(dbg_state), 64'h0);
    send_word(6'd5, OFF, 1'b0, 48'h0000_0000_003F, 1'b0, w);
    check("post_rst_accept_wait", 64'(w), 64'h0);
    send_word(6'd2, 10'd0, 1'b0, 48'h0000_0000_0007, 1'b1, w);
    wait_drain();
    check("no_done_after_abort", 64'(done_cnt - d0), 64'h0);
    check("post_rst_err_cnt", 64'(err_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_therm_decoder.md
TDC_THERM_DECODER -- requirements
Module: tdc_therm_decoder

Interface
REQ-001 Parameter INDEX, default 0: segment index; expected offset = INDEX*48, truncated to 10 bits.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 in_valid  input  1  encoded word present.
REQ-005 in_ready  output  1  block accepts word this cycle.
REQ-006 in_code  input  6  fine code, highest set thermometer bit position.
REQ-007 in_offset  input  10  coarse segment offset.
REQ-008 in_empty  input  1  segment empty flag (no hit).
REQ-009 sweep_start  input  1  one-cycle request to run self-test sweep.
REQ-010 out_valid  output  1  out_therm holds valid word.
REQ-011 out_ready  input  1  downstream accepts word.
REQ-012 out_therm  output  48  reconstructed thermometer word.
REQ-013 out_err  output  1  word flagged invalid; qualified by out_valid.
REQ-014 sweep_busy  output  1  sweep FSM not IDLE.
REQ-015 sweep_done  output  1  one-cycle pulse at sweep completion.
REQ-016 err_cnt  output  8  saturating count of error words accepted.

Function
REQ-017 Decode rule: in_empty=1 -> therm = 48'h0, err=0, in_code/in_offset ignored.
REQ-018 in_empty=0, in_code c<=47, in_offset==INDEX*48 -> therm bits [c:0]=1, bits [47:c+1]=0, err=0.
REQ-019 in_empty=0, in_code>47 -> therm = 48'h0, err=1.
REQ-020 in_empty=0, in_offset!=INDEX*48, in_code<=47 -> therm per REQ-018, err=1.
REQ-021 Latency: word accepted on cycle N (in_valid & in_ready) appears on out_therm/out_err with out_valid=1 from cycle N+1.
REQ-022 Single output register stage; in_ready = !out_valid | out_ready in decode mode; full throughput with out_ready held 1.
REQ-023 out_valid & !out_ready: out_therm, out_err, out_valid held stable; no word dropped or duplicated.
REQ-024 out_valid clears the cycle after out_valid & out_ready when no new word accepted.
REQ-025 Sweep FSM states: IDLE, SWEEP, DONE.
REQ-026 IDLE -> SWEEP on sweep_start=1; sweep counter loaded to 0.
REQ-027 In SWEEP, in_ready=0; generated word k: k=0 -> empty word (therm 0), k=1..48 -> code k-1 with correct offset.
REQ-028 Generated words use the same output register and handshake; counter advances only when word k is loaded into the output register.
REQ-029 SWEEP -> DONE after word k=48 loaded; DONE -> IDLE next cycle; sweep_done=1 only in DONE.
REQ-030 sweep_start while sweep_busy=1 ignored; sweep_start with in_valid=1 in IDLE: sweep wins, input word not accepted that cycle.
REQ-031 sweep_busy=1 in SWEEP and DONE.
REQ-032 err_cnt increments by 1 on each accepted word with err=1; holds at 255; sweep words never error.

Reset
REQ-033 rst_n=0 -> immediately: out_valid=0, out_therm=0, out_err=0, err_cnt=0, sweep_done=0, FSM=IDLE, sweep counter=0.
REQ-034 Reset mid-sweep aborts sweep; no sweep_done pulse; after release in_ready=1.
REQ-035 After rst_n deassert, first word accepted on first rising edge with in_valid=1.

Verification
REQ-036 INDEX=0, in_code=5, offset=0, empty=0, out_ready=1 -> next cycle out_therm=48'h00000000003F, out_err=0.
REQ-037 INDEX=2, in_code=47, offset=96 -> out_therm=48'hFFFFFFFFFFFF, err=0; offset=48 -> same therm, err=1, err_cnt=1.
REQ-038 in_code=50, empty=0 -> out_therm=0, out_err=1; empty=1 with code=50 -> therm=0, err=0.
REQ-039 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 while out_valid=1, output stable, resumes in order, no loss.
REQ-040 sweep_start pulse, out_ready=1 -> 49 words: 0, 0x1, 0x3, ... 0xFFFFFFFFFFFF; sweep_done one cycle; sweep_busy low after.
REQ-041 rst_n low at sweep word 20 -> outputs zero immediately, no sweep_done, normal decode after release.
